// File: rtl/commit_trace_rob_pkg.sv
// Shared types and sizing for the commit trace reorder buffer.
package commit_trace_rob_pkg;

  localparam int unsigned WADDR_BITS   = 5;
  localparam int unsigned SEQ_NUM_BITS = 5;
  localparam int unsigned ADDR_BITS    = 32;
  localparam int unsigned DATA_BITS    = 32;

  function automatic int unsigned rob_depth(input int unsigned seq_bits);
    return 32'(1) << seq_bits;
  endfunction

  localparam int unsigned DEPTH = rob_depth(SEQ_NUM_BITS);

  typedef struct packed {
    logic [ADDR_BITS-1:0]  pc;
    logic [WADDR_BITS-1:0] waddr;
    logic                  wen;
    logic [DATA_BITS-1:0]  wdata;
  } commit_rec_t;

endpackage

// File: rtl/commit_trace_rob_if.sv
// Allocation / completion / trace bundle for commit_trace_rob.
// Squash pins exist only when COMMIT_TRACE_ROB_SQUASH_EN is defined.
interface commit_trace_rob_if
  import commit_trace_rob_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = SEQ_NUM_BITS,
  parameter int unsigned p_addr_bits    = ADDR_BITS,
  parameter int unsigned p_data_bits    = DATA_BITS
);

  logic                      alloc_en;
  logic                      alloc_rdy;
  logic [p_seq_num_bits-1:0] alloc_seq_num;

  logic                      cmp_val;
  logic [p_seq_num_bits-1:0] cmp_seq_num;
  logic [p_addr_bits-1:0]    cmp_pc;
  logic [WADDR_BITS-1:0]     cmp_waddr;
  logic [p_data_bits-1:0]    cmp_wdata;
  logic                      cmp_wen;

  logic                      trace_val;
  logic                      trace_rdy;
  logic [p_addr_bits-1:0]    trace_pc;
  logic [WADDR_BITS-1:0]     trace_waddr;
  logic [p_data_bits-1:0]    trace_wdata;
  logic                      trace_wen;

`ifdef COMMIT_TRACE_ROB_SQUASH_EN
  logic                      squash_val;
  logic [p_seq_num_bits-1:0] squash_seq_num;
`endif

  modport master (
    output alloc_en,
    input  alloc_rdy,
    input  alloc_seq_num,
    output cmp_val,
    output cmp_seq_num,
    output cmp_pc,
    output cmp_waddr,
    output cmp_wdata,
    output cmp_wen,
`ifdef COMMIT_TRACE_ROB_SQUASH_EN
    output squash_val,
    output squash_seq_num,
`endif
    input  trace_val,
    output trace_rdy,
    input  trace_pc,
    input  trace_waddr,
    input  trace_wdata,
    input  trace_wen
  );

  modport slave (
    input  alloc_en,
    output alloc_rdy,
    output alloc_seq_num,
    input  cmp_val,
    input  cmp_seq_num,
    input  cmp_pc,
    input  cmp_waddr,
    input  cmp_wdata,
    input  cmp_wen,
`ifdef COMMIT_TRACE_ROB_SQUASH_EN
    input  squash_val,
    input  squash_seq_num,
`endif
    output trace_val,
    input  trace_rdy,
    output trace_pc,
    output trace_waddr,
    output trace_wdata,
    output trace_wen
  );

endinterface

// File: rtl/commit_trace_rob_ptr.sv
// Head/tail pointer pair with wrap bit; full when low bits match and wrap bits differ.
// With COMMIT_TRACE_ROB_SQUASH_EN the tail can also be loaded directly.
module commit_trace_rob_ptr #(
  parameter int unsigned p_seq_num_bits = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    head_inc,
  input  logic                    tail_inc,
`ifdef COMMIT_TRACE_ROB_SQUASH_EN
  input  logic                    tail_load,
  input  logic [p_seq_num_bits:0] tail_load_val,
`endif
  output logic [p_seq_num_bits:0] head,
  output logic [p_seq_num_bits:0] tail,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned SN = p_seq_num_bits;
  localparam int unsigned PW = p_seq_num_bits + 1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (head_inc) head <= head + PW'(1);
`ifdef COMMIT_TRACE_ROB_SQUASH_EN
      if (tail_load)     tail <= tail_load_val;
      else if (tail_inc) tail <= tail + PW'(1);
`else
      if (tail_inc) tail <= tail + PW'(1);
`endif
    end
  end

  assign full  = (head[SN-1:0] == tail[SN-1:0]) && (head[SN] != tail[SN]);
  assign empty = (head == tail);

endmodule

// File: rtl/commit_trace_rob.sv
// Reorders out-of-order completions into program-order commit trace records.
// Optional squash support is enabled by COMMIT_TRACE_ROB_SQUASH_EN.
module commit_trace_rob
  import commit_trace_rob_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = SEQ_NUM_BITS,
  parameter int unsigned p_addr_bits    = ADDR_BITS,
  parameter int unsigned p_data_bits    = DATA_BITS
) (
  input  logic              clk,
  input  logic              rst,
  commit_trace_rob_if.slave bus,
  output logic              err
);

  localparam int unsigned SN          = p_seq_num_bits;
  localparam int unsigned PW          = p_seq_num_bits + 1;
  localparam int unsigned NUM_ENTRIES = rob_depth(p_seq_num_bits);

  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic                   full;
  logic                   empty;
  logic [SN-1:0]          head_idx;
  logic [SN-1:0]          tail_idx;

  logic [NUM_ENTRIES-1:0] alloc_q;
  logic [NUM_ENTRIES-1:0] done_q;
  logic [NUM_ENTRIES-1:0] alloc_d;
  logic [NUM_ENTRIES-1:0] done_d;
  logic [NUM_ENTRIES-1:0] kill_c;

  logic [p_addr_bits-1:0] pc_q    [NUM_ENTRIES];
  logic [WADDR_BITS-1:0]  waddr_q [NUM_ENTRIES];
  logic [p_data_bits-1:0] wdata_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] wen_q;

  logic do_alloc_c;
  logic do_retire_c;
  logic cmp_ok_c;
  logic cmp_drop_c;
  logic cmp_err_c;
  logic squash_err_c;

  assign head_idx = head[SN-1:0];
  assign tail_idx = tail[SN-1:0];

`ifdef COMMIT_TRACE_ROB_SQUASH_EN
  logic          squash_ok_c;
  logic [SN-1:0] squash_off_c;
  logic [PW-1:0] squash_tail_c;

  // Entries whose distance from head exceeds the squash point are younger and get discarded.
  always_comb begin
    squash_ok_c   = bus.squash_val & alloc_q[bus.squash_seq_num];
    squash_off_c  = SN'(bus.squash_seq_num - head_idx);
    squash_tail_c = PW'(head + PW'(squash_off_c) + PW'(1));
    kill_c        = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      kill_c[i] = squash_ok_c & (SN'(SN'(i) - head_idx) > squash_off_c);
    end
  end

  assign squash_err_c = bus.squash_val & ~squash_ok_c;
  assign do_alloc_c   = bus.alloc_en & ~full & ~bus.squash_val;
`else
  assign kill_c       = '0;
  assign squash_err_c = 1'b0;
  assign do_alloc_c   = bus.alloc_en & ~full;
`endif

  commit_trace_rob_ptr #(
    .p_seq_num_bits (p_seq_num_bits)
  ) u_ptr (
    .clk           (clk),
    .rst           (rst),
    .head_inc      (do_retire_c),
    .tail_inc      (do_alloc_c),
`ifdef COMMIT_TRACE_ROB_SQUASH_EN
    .tail_load     (squash_ok_c),
    .tail_load_val (squash_tail_c),
`endif
    .head          (head),
    .tail          (tail),
    .full          (full),
    .empty         (empty)
  );

  assign bus.alloc_rdy     = ~full;
  assign bus.alloc_seq_num = tail_idx;

  // Trace fields come straight from head-entry registers, never from cmp_*.
  assign bus.trace_val   = ~empty & alloc_q[head_idx] & done_q[head_idx];
  assign bus.trace_pc    = pc_q[head_idx];
  assign bus.trace_waddr = waddr_q[head_idx];
  assign bus.trace_wdata = wdata_q[head_idx];
  assign bus.trace_wen   = wen_q[head_idx];

  assign do_retire_c = bus.trace_val & bus.trace_rdy;

  assign cmp_drop_c = bus.cmp_val & kill_c[bus.cmp_seq_num] & alloc_q[bus.cmp_seq_num];
  assign cmp_ok_c   = bus.cmp_val & alloc_q[bus.cmp_seq_num] & ~done_q[bus.cmp_seq_num]
                    & ~kill_c[bus.cmp_seq_num];
  assign cmp_err_c  = bus.cmp_val & ~cmp_ok_c & ~cmp_drop_c;

  always_comb begin
    alloc_d = alloc_q & ~kill_c;
    done_d  = done_q & ~kill_c;
    if (do_retire_c) begin
      alloc_d[head_idx] = 1'b0;
      done_d[head_idx]  = 1'b0;
    end
    if (do_alloc_c) begin
      alloc_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
    end
    if (cmp_ok_c) begin
      done_d[bus.cmp_seq_num] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_q <= '0;
      done_q  <= '0;
      wen_q   <= '0;
      err     <= 1'b0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        pc_q[i]    <= '0;
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
      end
    end else begin
      alloc_q <= alloc_d;
      done_q  <= done_d;
      err     <= err | cmp_err_c | squash_err_c;
      if (cmp_ok_c) begin
        pc_q[bus.cmp_seq_num]    <= bus.cmp_pc;
        waddr_q[bus.cmp_seq_num] <= bus.cmp_waddr;
        wdata_q[bus.cmp_seq_num] <= bus.cmp_wdata;
        wen_q[bus.cmp_seq_num]   <= bus.cmp_wen;
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_rob.sv
// Directed self-checking bench for commit_trace_rob (squash cases need COMMIT_TRACE_ROB_SQUASH_EN).
module tb_commit_trace_rob;
  import commit_trace_rob_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        err;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  commit_trace_rob_if bus ();

  commit_trace_rob dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic commit_rec_t make_rec(input logic [31:0] pc, input logic [4:0] waddr,
                                           input logic [31:0] wdata, input logic wen);
    commit_rec_t r;
    r.pc    = pc;
    r.waddr = waddr;
    r.wdata = wdata;
    r.wen   = wen;
    return r;
  endfunction

  task automatic idle();
    bus.alloc_en    = 1'b0;
    bus.cmp_val     = 1'b0;
    bus.cmp_seq_num = '0;
    bus.cmp_pc      = '0;
    bus.cmp_waddr   = '0;
    bus.cmp_wdata   = '0;
    bus.cmp_wen     = 1'b0;
    bus.trace_rdy   = 1'b0;
`ifdef COMMIT_TRACE_ROB_SQUASH_EN
    bus.squash_val     = 1'b0;
    bus.squash_seq_num = '0;
`endif
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic alloc_n(input string tag, input int n, input int first);
    for (int k = 0; k < n; k++) begin
      bus.alloc_en = 1'b1;
      check($sformatf("%s_alloc_rdy%0d", tag, k), 64'(bus.alloc_rdy), 64'(1));
      check($sformatf("%s_alloc_seq%0d", tag, k), 64'(bus.alloc_seq_num), 64'((first + k) % 32));
      tick();
    end
    bus.alloc_en = 1'b0;
  endtask

  task automatic complete(input int seq, input commit_rec_t r);
    bus.cmp_val     = 1'b1;
    bus.cmp_seq_num = 5'(seq);
    bus.cmp_pc      = r.pc;
    bus.cmp_waddr   = r.waddr;
    bus.cmp_wdata   = r.wdata;
    bus.cmp_wen     = r.wen;
    tick();
    bus.cmp_val     = 1'b0;
  endtask

  task automatic check_rec(input string tag, input commit_rec_t e);
    check({tag, "_val"},   64'(bus.trace_val),   64'(1));
    check({tag, "_pc"},    64'(bus.trace_pc),    64'(e.pc));
    check({tag, "_waddr"}, 64'(bus.trace_waddr), 64'(e.waddr));
    check({tag, "_wdata"}, 64'(bus.trace_wdata), 64'(e.wdata));
    check({tag, "_wen"},   64'(bus.trace_wen),   64'(e.wen));
  endtask

  function automatic commit_rec_t full_rec(input int i);
    return make_rec(32'(32'h1000 + 4 * i), 5'(i), 32'(32'h100 + i), 1'(i & 1));
  endfunction

  initial begin
    commit_rec_t r;
    rst = 1'b0;
    idle();

    // Reset state
    reset_dut();
    check("rst_trace_val", 64'(bus.trace_val), 64'(0));
    check("rst_alloc_rdy", 64'(bus.alloc_rdy), 64'(1));
    check("rst_alloc_seq", 64'(bus.alloc_seq_num), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_trace_pc", 64'(bus.trace_pc), 64'(0));
    check("rst_trace_wdata", 64'(bus.trace_wdata), 64'(0));

    // In-order completions, one record per cycle, one cycle after completion
    alloc_n("inord", 3, 0);
    bus.trace_rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      r = make_rec(32'(32'h200 + 4 * s), 5'(s + 1), 32'(5 + s), 1'b1);
      complete(s, r);
      check_rec($sformatf("inord%0d", s), r);
    end
    tick();
    check("inord_drained", 64'(bus.trace_val), 64'(0));

    // Out-of-order completions held until the head completes
    reset_dut();
    alloc_n("ooo", 4, 0);
    bus.trace_rdy = 1'b1;
    complete(3, make_rec(32'h30c, 5'd11, 32'hA3, 1'b1));
    check("ooo_wait3", 64'(bus.trace_val), 64'(0));
    complete(1, make_rec(32'h304, 5'd9, 32'hA1, 1'b1));
    check("ooo_wait1", 64'(bus.trace_val), 64'(0));
    complete(2, make_rec(32'h308, 5'd10, 32'hA2, 1'b0));
    check("ooo_wait2", 64'(bus.trace_val), 64'(0));
    complete(0, make_rec(32'h300, 5'd8, 32'hA0, 1'b0));
    for (int s = 0; s < 4; s++) begin
      check_rec($sformatf("ooo%0d", s),
                make_rec(32'(32'h300 + 4 * s), 5'(8 + s), 32'(32'hA0 + s), 1'((s == 1) || (s == 3))));
      tick();
    end
    check("ooo_drained", 64'(bus.trace_val), 64'(0));

    // Full buffer, backpressure, retire-then-alloc
    reset_dut();
    alloc_n("full", 32, 0);
    check("full_alloc_rdy", 64'(bus.alloc_rdy), 64'(0));
    check("full_alloc_seq", 64'(bus.alloc_seq_num), 64'(0));
    bus.alloc_en = 1'b1;
    tick();
    bus.alloc_en = 1'b0;
    check("full_ignored_rdy", 64'(bus.alloc_rdy), 64'(0));
    check("full_ignored_seq", 64'(bus.alloc_seq_num), 64'(0));
    for (int i = 0; i < 32; i++) complete(i, full_rec(i));
    check_rec("full_held", full_rec(0));
    tick();
    check_rec("full_held2", full_rec(0));
    bus.trace_rdy = 1'b1;
    bus.alloc_en  = 1'b1;
    check("full_pre_retire_rdy", 64'(bus.alloc_rdy), 64'(0));
    tick();
    check("full_post_retire_rdy", 64'(bus.alloc_rdy), 64'(1));
    check("full_post_retire_seq", 64'(bus.alloc_seq_num), 64'(0));
    check_rec("full_rec1", full_rec(1));
    tick();
    bus.alloc_en = 1'b0;
    check("full_realloc_seq", 64'(bus.alloc_seq_num), 64'(1));
    for (int s = 2; s < 32; s++) begin
      check_rec($sformatf("full_rec%0d", s), full_rec(s));
      tick();
    end
    check("full_new0_pending", 64'(bus.trace_val), 64'(0));
    r = make_rec(32'h2000, 5'd3, 32'hDEAD, 1'b1);
    complete(0, r);
    check_rec("full_new0", r);
    tick();
    check("full_end_val", 64'(bus.trace_val), 64'(0));
    check("full_end_err", 64'(err), 64'(0));

    // Completion to an unallocated entry
    reset_dut();
    alloc_n("err7", 1, 0);
    complete(7, make_rec(32'h700, 5'd7, 32'h77, 1'b1));
    check("err_unalloc_err", 64'(err), 64'(1));
    check("err_unalloc_val", 64'(bus.trace_val), 64'(0));

    // Double completion keeps the first data
    reset_dut();
    alloc_n("dbl", 1, 0);
    r = make_rec(32'h400, 5'd4, 32'hAA, 1'b1);
    complete(0, r);
    check("dbl_first_err", 64'(err), 64'(0));
    complete(0, make_rec(32'h500, 5'd5, 32'hBB, 1'b0));
    check("dbl_second_err", 64'(err), 64'(1));
    check_rec("dbl_kept", r);

    // Asynchronous reset between clock edges
    reset_dut();
    alloc_n("arst", 5, 0);
    complete(0, make_rec(32'h800, 5'd1, 32'h1, 1'b1));
    complete(1, make_rec(32'h804, 5'd2, 32'h2, 1'b1));
    check("arst_pending_val", 64'(bus.trace_val), 64'(1));
    #3;
    rst = 1'b0;
    #1;
    check("arst_val", 64'(bus.trace_val), 64'(0));
    check("arst_rdy", 64'(bus.alloc_rdy), 64'(1));
    check("arst_seq", 64'(bus.alloc_seq_num), 64'(0));
    check("arst_pc", 64'(bus.trace_pc), 64'(0));
    #2;
    rst = 1'b1;
    tick();
    check("arst_after_val", 64'(bus.trace_val), 64'(0));
    alloc_n("arst_after", 2, 0);

`ifdef COMMIT_TRACE_ROB_SQUASH_EN
    // Squash younger entries; same-cycle alloc ignored
    reset_dut();
    alloc_n("sq", 6, 0);
    bus.squash_val     = 1'b1;
    bus.squash_seq_num = 5'd2;
    bus.alloc_en       = 1'b1;
    tick();
    bus.squash_val = 1'b0;
    bus.alloc_en   = 1'b0;
    check("sq_tail", 64'(bus.alloc_seq_num), 64'(3));
    check("sq_err0", 64'(err), 64'(0));
    bus.trace_rdy = 1'b1;
    for (int s = 0; s < 3; s++) begin
      r = make_rec(32'(32'h600 + 4 * s), 5'(s), 32'(32'h60 + s), 1'b1);
      complete(s, r);
      check_rec($sformatf("sq%0d", s), r);
    end
    tick();
    check("sq_drained", 64'(bus.trace_val), 64'(0));
    complete(4, make_rec(32'h610, 5'd4, 32'h64, 1'b1));
    check("sq_err4", 64'(err), 64'(1));
    check("sq_no_rec", 64'(bus.trace_val), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_rob.md
Name: commit_trace_rob

Overview:
- Reorders out-of-order instruction completions back into program order.
- Emits one commit record per instruction (pc, waddr, wdata, wen) on a val/rdy stream.
- Sits between the processor's writeback/completion ports and the trace checker used by the processor-level test harness.
- Records leave in the same order and format as functional-level processor trace records, so cycle-level and FL traces compare one-to-one.

Parameters:
- p_seq_num_bits, 5, sequence-number width; depth = 2**p_seq_num_bits entries (default 32)
- p_addr_bits, 32, pc width
- p_data_bits, 32, writeback data width

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- alloc_en  in  1  allocate next sequence number (in-order issue)
- alloc_rdy  out  1  an entry is free
- alloc_seq_num  out  p_seq_num_bits  sequence number granted when alloc_en & alloc_rdy
- cmp_val  in  1  completion valid; always accepted
- cmp_seq_num  in  p_seq_num_bits  completing instruction's sequence number
- cmp_pc  in  p_addr_bits  completing instruction's pc
- cmp_waddr  in  5  destination register
- cmp_wdata  in  p_data_bits  writeback data
- cmp_wen  in  1  register write enable
- trace_val  out  1  head record valid
- trace_rdy  in  1  consumer accepts record
- trace_pc  out  p_addr_bits  head record fields
- trace_waddr  out  5  head record fields
- trace_wdata  out  p_data_bits  head record fields
- trace_wen  out  1  head record fields
- err  out  1  sticky protocol-error flag

Behaviour:
- Storage:
  - circular buffer with head and tail pointers, each p_seq_num_bits+1 wide (extra wrap bit)
  - per-entry alloc bit and done bit
- Reset (rst=0, async):
  - head=tail=0; all alloc/done bits cleared
  - trace_val=0, alloc_rdy=1, alloc_seq_num=0, err=0
  - record fields reset to 0
  - reset mid-operation discards every entry
- Allocation:
  - alloc_rdy = !full, where full means the pointer low bits are equal and the wrap bits differ
  - alloc_seq_num = tail low bits
  - on alloc_en & alloc_rdy: set alloc bit, clear done bit, tail += 1 (wraps modulo 2**(p_seq_num_bits+1))
  - alloc_en while !alloc_rdy is ignored
- Completion:
  - on cmp_val: write the fields into entry cmp_seq_num and set its done bit
  - completions may arrive in any order
  - completion to a non-allocated entry, or to an already-done entry: write suppressed, err set (sticky until reset)
- Output:
  - trace_val = alloc[head] & done[head]
  - fields are driven directly from the head entry's registers; no combinational path from cmp_* to trace_*
  - minimum latency is 1 cycle from completion to trace_val
- Retire:
  - on trace_val & trace_rdy: clear the head entry's alloc/done bits, head += 1
  - trace_val with trace_rdy=0 holds the record stable
- Simultaneous events:
  - alloc and retire in the same cycle are both performed
  - alloc_rdy is computed from the pre-retire state (no full pass-through)
  - when the buffer is full and a retire occurs, the free slot becomes visible next cycle
  - completion and retire in one cycle are always to different entries
- Empty (head==tail): trace_val=0.
- Wrap-around: sequence numbers reuse after 2**p_seq_num_bits allocations; correctness is guaranteed by the full check.

Optional Feature:
- Macro: COMMIT_TRACE_ROB_SQUASH_EN
- With the macro defined:
  - adds ports squash_val (in, 1) and squash_seq_num (in, p_seq_num_bits)
  - squash_val discards every allocated entry strictly younger than squash_seq_num (alloc/done cleared) and sets tail = squash_seq_num+1, keeping the wrap bit consistent
  - squash has priority over a same-cycle alloc_en (alloc ignored, alloc_rdy still reported)
  - a same-cycle completion to a squashed entry is dropped without setting err
  - a squash_seq_num that is not allocated sets err
- Without the macro: no squash ports; tail only advances on allocation.

Decomposition:
- Shared package (e.g. CommitTracePkg) holds:
  - typedef commit_rec_t {pc, waddr, wen, wdata}
  - localparam for waddr width (5)
  - the depth derivation
- One natural sub-module, commit_trace_rob_ptr: head/tail pointer pair with wrap bit, full/empty, and increment (plus squash load when enabled); instantiated once.

Test Plan:
- In-order: alloc seq 0,1,2; complete 0 (pc 0x200, x1, 0x5, wen=1), then 1, then 2; trace_rdy=1 -> records pc 0x200, 0x204, 0x208 in order, one per cycle, each 1 cycle after its completion.
- Out-of-order: alloc 0..3; complete 3,1,2 -> trace_val=0 throughout; then complete 0 -> pc of 0,1,2,3 on 4 consecutive cycles.
- Full/backpressure: 32 allocs -> alloc_rdy=0, alloc_seq_num wraps to 0; complete all with trace_rdy=0 -> record 0 held stable; then raise trace_rdy with alloc_en=1 -> alloc_rdy returns 1 cycle after the first retire; the new sequence number 0 does not corrupt retired data.
- Errors: complete unallocated seq 7 -> err=1, no trace; double-complete seq 0 -> err=1, first data kept.
- Async reset mid-stream: with 5 entries pending, assert rst=0 between edges -> trace_val=0 and alloc_rdy=1 immediately; after release, the first alloc returns seq 0.
- (COMMIT_TRACE_ROB_SQUASH_EN) alloc 0..5; squash at 2 -> tail=3; complete 0,1,2 -> exactly 3 records; completion to 4 -> err=1.
